// File: rtl/pivot_pkg.sv
// rtl/pivot_pkg.sv - shared types, constants and address split for the pivot ROM cache
// Contents:
//   PIVOT_ROM_SDR_BASE  27-bit SDRAM byte base of the pivot-layer ROM image
//   cache_state_t       cache controller states
//   line_t              one 64-bit cache line (4 x 16-bit words)
//   split_addr()        client byte address -> {tag, index, word}
package pivot_pkg;

  localparam logic [26:0] PIVOT_ROM_SDR_BASE = 27'h0200000;

  typedef enum logic [2:0] {IDLE, LOOKUP, COMPARE, FILL, FLUSH} cache_state_t;

  typedef logic [63:0] line_t;

  // Fields are sized for the largest supported cache (256 lines, 20-bit tag
  // at 16 lines); callers slice them down to their own IDX_W / TAG_W.
  typedef struct packed {
    logic [26:0] tag;
    logic [7:0]  index;
    logic [1:0]  word;
  } addr_split_t;

  function automatic addr_split_t split_addr(input logic [26:0] addr, input int idx_w);
    addr_split_t s;
    logic [26:0] idx_mask;
    idx_mask = (27'd1 << idx_w) - 27'd1;
    s.tag    = addr >> (3 + idx_w);
    s.index  = 8'((addr >> 3) & idx_mask);
    s.word   = addr[2:1];
    return s;
  endfunction

endpackage

// File: rtl/pivot_cache_ram.sv
// rtl/pivot_cache_ram.sv - 1R1W synchronous tag+data RAM for the pivot ROM cache
// Ports:
//   clk    in          clock
//   we     in          write enable
//   waddr  in  AW      write line index
//   wdata  in  W       {tag, line}
//   raddr  in  AW      read line index (registered read, data next clock)
//   rdata  out W       {tag, line}
// No reset: valid bits live in the controller so reset/flush can clear them.
module pivot_cache_ram
  import pivot_pkg::*;
#(
  parameter int LINES = 64,
  parameter int W     = 82
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(LINES)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(LINES)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [LINES];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/pivot_rom_cache.sv
// rtl/pivot_rom_cache.sv - direct-mapped read cache between pivot-layer ROM port and SDRAM arbiter
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   rom_address[26:0]         client byte address (bit 0 ignored)
//   rom_req / rom_ack         client toggle handshake, rom_data[15:0] returned word
//   flush                     one-clk pulse, invalidates all lines
//   sdr_addr[26:0]            SDRAM line byte address (bits [2:0] = 0)
//   sdr_req / sdr_ack         SDRAM toggle handshake, sdr_data[63:0] line (word0 in [15:0])
//   busy                      high whenever the controller is not IDLE
//   hit_count/miss_count      saturating statistics, only with PIVOT_CACHE_STATS_EN defined
module pivot_rom_cache
  import pivot_pkg::*;
#(
  parameter int          LINES    = 64,
  parameter logic [26:0] SDR_BASE = PIVOT_ROM_SDR_BASE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [26:0] rom_address,
  input  logic        rom_req,
  output logic [15:0] rom_data,
  output logic        rom_ack,
  input  logic        flush,
  output logic [26:0] sdr_addr,
  output logic        sdr_req,
  input  logic        sdr_ack,
  input  line_t       sdr_data,
  output logic        busy
`ifdef PIVOT_CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 24 - IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINES - 1);

  cache_state_t      state, state_n;
  logic              req_seen, cur_tog, pend, pend_tog, flush_pend;
  logic [26:0]       cur_addr, pend_addr;
  logic [LINES-1:0]  valid;
  logic [IDX_W-1:0]  flush_cnt, cur_idx;
  logic [TAG_W-1:0]  cur_tag, rd_tag;
  line_t             rd_line;
  addr_split_t       cur_s;
  logic              req_edge, go_flush, hit, enter_flush, unused_bits;
  logic              take_new, take_pend, hit_ret, issue_fill, fill_done;

  assign cur_s       = split_addr(cur_addr, IDX_W);
  assign cur_idx     = cur_s.index[IDX_W-1:0];
  assign cur_tag     = cur_s.tag[TAG_W-1:0];
  assign unused_bits = ^cur_s;
  assign req_edge    = rom_req != req_seen;
  assign go_flush    = flush | flush_pend;
  assign hit         = valid[cur_idx] && (rd_tag == cur_tag);
  assign busy        = state != IDLE;

  pivot_cache_ram #(.LINES(LINES), .W(TAG_W + 64)) u_ram (
    .clk   (clk),
    .we    (fill_done),
    .waddr (cur_idx),
    .wdata ({cur_tag, sdr_data}),
    .raddr (cur_idx),
    .rdata ({rd_tag, rd_line})
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n    = state;
    take_new   = 1'b0;
    take_pend  = 1'b0;
    hit_ret    = 1'b0;
    issue_fill = 1'b0;
    fill_done  = 1'b0;
    case (state)
      IDLE: begin
        // Flush beats any request; a pending request beats a fresh edge.
        if (go_flush) begin
          state_n = FLUSH;
        end else if (pend) begin
          take_pend = 1'b1;
          state_n   = LOOKUP;
        end else if (req_edge) begin
          take_new = 1'b1;
          state_n  = LOOKUP;
        end
      end
      LOOKUP: state_n = COMPARE;
      COMPARE: begin
        if (hit) begin
          hit_ret = 1'b1;
          state_n = go_flush ? FLUSH : IDLE;
        end else begin
          issue_fill = 1'b1;
          state_n    = FILL;
        end
      end
      FILL: begin
        if (sdr_ack == sdr_req) begin
          fill_done = 1'b1;
          state_n   = go_flush ? FLUSH : IDLE;
        end
      end
      FLUSH: if (!flush && flush_cnt == LAST_IDX) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign enter_flush = (state_n == FLUSH) && (state != FLUSH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_seen   <= 1'b0;
      pend       <= 1'b0;
      pend_tog   <= 1'b0;
      pend_addr  <= '0;
      cur_addr   <= '0;
      cur_tog    <= 1'b0;
      flush_pend <= 1'b0;
      flush_cnt  <= '0;
      valid      <= '0;
      rom_data   <= '0;
      rom_ack    <= 1'b0;
      sdr_addr   <= '0;
      sdr_req    <= 1'b0;
    end else begin
      req_seen <= rom_req;
      // Any edge not taken straight from IDLE lands in the one-deep slot;
      // a newer edge overwrites it, and a refill wins over the slot being drained.
      if (req_edge && !take_new) begin
        pend      <= 1'b1;
        pend_addr <= rom_address;
        pend_tog  <= rom_req;
      end else if (take_pend) begin
        pend <= 1'b0;
      end
      if (take_new) begin
        cur_addr <= rom_address;
        cur_tog  <= rom_req;
      end else if (take_pend) begin
        cur_addr <= pend_addr;
        cur_tog  <= pend_tog;
      end

      if (enter_flush)
        flush_pend <= 1'b0;
      else if (flush && (state == LOOKUP || state == COMPARE || state == FILL))
        flush_pend <= 1'b1;

      if (enter_flush)         flush_cnt <= '0;
      else if (state == FLUSH) flush_cnt <= flush ? '0 : flush_cnt + 1'b1;
      if (state == FLUSH) valid[flush_cnt] <= 1'b0;
      // A line fetched across a flush is returned but never marked valid.
      if (fill_done && !go_flush) valid[cur_idx] <= 1'b1;

      // The ack carries the toggle of the request being served, not the latest one.
      if (hit_ret) begin
        rom_data <= rd_line[{cur_s.word, 4'b0000} +: 16];
        rom_ack  <= cur_tog;
      end
      if (fill_done) begin
        rom_data <= sdr_data[{cur_s.word, 4'b0000} +: 16];
        rom_ack  <= cur_tog;
      end
      if (issue_fill) begin
        sdr_addr <= SDR_BASE + {cur_tag, cur_idx, 3'b000};
        sdr_req  <= ~sdr_req;
      end
    end
  end

`ifdef PIVOT_CACHE_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (flush) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_ret && hit_count != '1)     hit_count  <= hit_count + 1'b1;
      if (issue_fill && miss_count != '1) miss_count <= miss_count + 1'b1;
    end
  end
`else
  // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_pivot_rom_cache.sv
// tb/tb_pivot_rom_cache.sv - directed scoreboard bench for pivot_rom_cache
module tb_pivot_rom_cache;

  localparam int          LINES = 64;
  localparam logic [26:0] BASE  = 27'h0200000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [26:0] rom_address = '0;
  logic        rom_req = 1'b0;
  logic [15:0] rom_data;
  logic        rom_ack;
  logic        flush = 1'b0;
  logic [26:0] sdr_addr;
  logic        sdr_req;
  logic        sdr_ack = 1'b0;
  logic [63:0] sdr_data = '0;
  logic        busy;

  logic        stall = 1'b0;
  int          stale_cnt = 0;
  int          stale_done = 0;
  int          wait_cnt = 0;
  logic        prev_sdr_req = 1'b0;
  logic [26:0] exp_sdr[$];
  logic [15:0] exp_data[$];
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  pivot_rom_cache #(.LINES(LINES), .SDR_BASE(BASE)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rom_address (rom_address),
    .rom_req     (rom_req),
    .rom_data    (rom_data),
    .rom_ack     (rom_ack),
    .flush       (flush),
    .sdr_addr    (sdr_addr),
    .sdr_req     (sdr_req),
    .sdr_ack     (sdr_ack),
    .sdr_data    (sdr_data),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Line contents keyed by offset from BASE; 0x40 carries the documented pattern.
  function automatic logic [63:0] line_data(input logic [26:0] off);
    logic [63:0] d;
    if (off == 27'h40) return 64'h4444_3333_2222_1111;
    for (int w = 0; w < 4; w++) d[16*w +: 16] = 16'h8000 | (16'(off[14:3]) << 2) | 16'(w);
    return d;
  endfunction

  function automatic logic [15:0] exp_word(input logic [26:0] a);
    logic [63:0] l;
    l = line_data({a[26:3], 3'b000});
    return l[{a[2:1], 4'b0000} +: 16];
  endfunction

  // SDRAM arbiter model, reset in the same domain as the cache.
  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sdr_ack    = 1'b0;
      wait_cnt   = 0;
      stale_done = stale_cnt;
    end else if (stale_cnt != stale_done) begin
      sdr_ack    = ~sdr_ack;
      stale_done = stale_cnt;
    end else if (sdr_req !== sdr_ack && !stall) begin
      if (wait_cnt < 2) wait_cnt++;
      else begin
        sdr_data = line_data(sdr_addr - BASE);
        sdr_ack  = sdr_req;
        wait_cnt = 0;
      end
    end
  end

  // Every sdr_req toggle must match the next expected line address.
  always @(negedge clk) begin
    logic [26:0] e;
    if (!reset_n) prev_sdr_req = 1'b0;
    else if (sdr_req !== prev_sdr_req) begin
      prev_sdr_req = sdr_req;
      e = (exp_sdr.size() != 0) ? exp_sdr.pop_front() : 27'h7FFFFFF;
      check("sdr_addr", 64'(sdr_addr), 64'(e));
    end
  end

  task automatic send(input logic [26:0] a);
    @(posedge clk); #1;
    rom_address = a;
    rom_req     = ~rom_req;
  endtask

  task automatic wait_done(input string tag);
    int idle_run = 0;
    int cyc = 0;
    logic [15:0] e;
    while (idle_run < 2 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (rom_ack === rom_req && busy === 1'b0) idle_run++;
      else idle_run = 0;
    end
    check({tag, "_complete"}, 64'(idle_run == 2), 64'd1);
    e = (exp_data.size() != 0) ? exp_data.pop_front() : 16'hDEAD;
    check(tag, 64'(rom_data), 64'(e));
  endtask

  task automatic wait_fill(input string tag);
    int cyc = 0;
    while (sdr_req === sdr_ack && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_fill_start"}, 64'(sdr_req !== sdr_ack), 64'd1);
  endtask

  task automatic pulse_flush();
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
  endtask

  task automatic count_busy(input string tag);
    int cnt = 0;
    @(negedge clk);
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    check(tag, 64'(cnt), 64'(LINES));
  endtask

  initial begin
    logic exp_b;
    int   cyc;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rom_data", 64'(rom_data), 64'd0);
    check("reset_rom_ack",  64'(rom_ack),  64'd0);
    check("reset_sdr_req",  64'(sdr_req),  64'd0);
    check("reset_sdr_addr", 64'(sdr_addr), 64'd0);
    check("reset_busy",     64'(busy),     64'd0);
    reset_n = 1'b1;

    // Cold miss
    exp_sdr.push_back(BASE + 27'h40);
    exp_data.push_back(16'h1111);
    send(27'h40);
    wait_done("cold_miss");
    check("cold_ack", 64'(rom_ack), 64'(rom_req));

    // Hit: ack must toggle on the third clock after the request edge
    exp_data.push_back(16'h4444);
    send(27'h46);
    repeat (2) @(posedge clk);
    #1 exp_b = ~rom_req;
    check("hit_ack_early", 64'(rom_ack), 64'(exp_b));
    @(posedge clk);
    #1 check("hit_ack_3clk", 64'(rom_ack), 64'(rom_req));
    check("hit_data", 64'(rom_data), 64'(exp_data.pop_front()));
    repeat (2) @(posedge clk);

    // Conflict eviction on index 8
    exp_sdr.push_back(BASE + 27'h240);
    exp_data.push_back(exp_word(27'h240));
    send(27'h240);
    wait_done("evict_fill");
    exp_sdr.push_back(BASE + 27'h40);
    exp_data.push_back(16'h1111);
    send(27'h40);
    wait_done("evict_remiss");

    // Three toggles during a stalled fill: 0x100 then 0x110 only
    stall = 1'b1;
    exp_sdr.push_back(BASE + 27'h100);
    exp_sdr.push_back(BASE + 27'h110);
    exp_data.push_back(exp_word(27'h110));
    send(27'h100);
    wait_fill("b2b");
    send(27'h108);
    repeat (2) @(posedge clk);
    send(27'h110);
    repeat (3) @(posedge clk);
    stall = 1'b0;
    wait_done("b2b_last");
    check("b2b_final_ack", 64'(rom_ack), 64'(rom_req));

    // Flush during a fill
    stall = 1'b1;
    exp_sdr.push_back(BASE + 27'h300);
    send(27'h300);
    wait_fill("flush_mid");
    pulse_flush();
    stall = 1'b0;
    cyc = 0;
    while (rom_ack !== rom_req && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("flush_mid_ack", 64'(rom_ack), 64'(rom_req));
    check("flush_mid_data", 64'(rom_data), 64'(exp_word(27'h300)));
    begin
      int cnt = 0;
      while (busy === 1'b1 && cnt < 200) begin
        cnt++;
        @(negedge clk);
      end
      check("flush_mid_busy_len", 64'(cnt), 64'(LINES));
    end
    exp_sdr.push_back(BASE + 27'h300);
    exp_data.push_back(exp_word(27'h306));
    send(27'h306);
    wait_done("flush_mid_remiss");

    // Flush restarted while flushing
    pulse_flush();
    repeat (10) @(posedge clk);
    pulse_flush();
    count_busy("flush_restart_len");

    // Flush and request together in IDLE: flush first, request then misses
    exp_sdr.push_back(BASE + 27'h300);
    exp_data.push_back(exp_word(27'h302));
    @(posedge clk); #1;
    flush       = 1'b1;
    rom_address = 27'h302;
    rom_req     = ~rom_req;
    @(posedge clk); #1 flush = 1'b0;
    count_busy("flush_req_len");
    wait_done("flush_req_miss");

    // Asynchronous reset during a fill
    stall = 1'b1;
    exp_sdr.push_back(BASE + 27'h180);
    send(27'h180);
    wait_fill("rst_mid");
    @(negedge clk);
    #2 reset_n = 1'b0;
    rom_req = 1'b0;
    #1;
    check("rst_rom_data", 64'(rom_data), 64'd0);
    check("rst_rom_ack",  64'(rom_ack),  64'd0);
    check("rst_sdr_req",  64'(sdr_req),  64'd0);
    check("rst_sdr_addr", 64'(sdr_addr), 64'd0);
    check("rst_busy",     64'(busy),     64'd0);
    repeat (3) @(negedge clk);
    stall = 1'b0;
    reset_n = 1'b1;
    stale_cnt++;
    repeat (8) @(negedge clk);
    check("stale_ack_rom_ack", 64'(rom_ack), 64'd0);
    check("stale_ack_busy",    64'(busy),    64'd0);
    exp_sdr.push_back(BASE + 27'h40);
    exp_data.push_back(16'h1111);
    send(27'h40);
    wait_done("post_reset_miss");

    repeat (5) @(negedge clk);
    check("sdr_queue_left",  64'(exp_sdr.size()),  64'd0);
    check("data_queue_left", 64'(exp_data.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
